// File: rtl/mem_io_bus.sv
// Multi-cycle load/store path from the CPU to data memory and N memory-mapped IO channels.
// Stores to memory take one stall cycle, loads MEM_LAT+1; IO waits on the selected io_ready or times out.
module mem_io_bus #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         N_IO      = 4,
  parameter logic [ADDR_W-1:0]   IO_BASE   = 'hFFFF_FC00,
  parameter int unsigned         IO_STRIDE = 16,
  parameter int unsigned         MEM_LAT   = 1,
  parameter int unsigned         TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         cpu_err,
  output logic [ADDR_W-1:0]            err_addr,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [N_IO-1:0]              io_sel,
  output logic                         io_we,
  output logic [$clog2(IO_STRIDE)-1:0] io_addr,
  output logic [DATA_W-1:0]            io_wdata,
  input  logic [N_IO*DATA_W-1:0]       io_rdata,
  input  logic [N_IO-1:0]              io_ready
);

  localparam int unsigned OFF_W   = $clog2(IO_STRIDE);
  localparam int unsigned K_W     = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W-1:0] IO_SPAN  = ADDR_W'(N_IO * IO_STRIDE);
  localparam logic [CNT_W-1:0]  MEM_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEM_RD, S_IO_WAIT, S_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [K_W-1:0]     chan_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q;
  logic [DATA_W-1:0]  cpu_rdata_q;
  logic [ADDR_W-1:0]  err_addr_q;
  logic               cpu_err_q;

  logic [ADDR_W-1:0]  io_off;
  logic               dec_mem;
  logic               dec_io;
  logic [K_W-1:0]     dec_chan;
  logic [DATA_W-1:0]  io_slice;
  logic               io_rdy_sel;

  // io_off wraps below IO_BASE, so the window test needs the dec_mem guard too
  assign io_off   = cpu_addr - IO_BASE;
  assign dec_mem  = cpu_addr < IO_BASE;
  assign dec_io   = !dec_mem && (io_off < IO_SPAN);
  assign dec_chan = io_off[OFF_W +: K_W];

  always_comb begin
    io_slice   = '0;
    io_rdy_sel = 1'b0;
    for (int i = 0; i < int'(N_IO); i++) begin
      if (chan_q == K_W'(i)) begin
        io_slice   = io_rdata[i*DATA_W +: DATA_W];
        io_rdy_sel = io_ready[i];
      end
    end
  end

  always_comb begin
    io_sel = '0;
    if (rst && state_q == S_IO_WAIT) begin
      for (int i = 0; i < int'(N_IO); i++) io_sel[i] = (chan_q == K_W'(i));
    end
  end

  // Memory strobes are gated by rst so an abort drops them in the same cycle
  assign mem_en    = rst && (state_q == S_IDLE) && cpu_req && dec_mem;
  assign mem_we    = mem_en && cpu_we;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  assign io_we     = rst && (state_q == S_IO_WAIT) && we_q;
  assign io_addr   = addr_q[OFF_W-1:0];
  assign io_wdata  = wdata_q;

  assign cpu_stall = cpu_req && (state_q != S_DONE);
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign err_addr  = err_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      chan_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      err_addr_q  <= '0;
      cpu_err_q   <= 1'b0;
    end else begin
      cpu_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            cnt_q <= '0;
            if (dec_mem) begin
              state_q <= cpu_we ? S_DONE : S_MEM_RD;
            end else if (dec_io) begin
              state_q <= S_IO_WAIT;
              chan_q  <= dec_chan;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
              we_q    <= cpu_we;
            end else begin
              state_q    <= S_DONE;
              cpu_err_q  <= 1'b1;
              err_addr_q <= cpu_addr;
              if (!cpu_we) cpu_rdata_q <= '0;
            end
          end
        end
        S_MEM_RD: begin
          if (cnt_q == MEM_LAST) begin
            cpu_rdata_q <= mem_rdata;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_IO_WAIT: begin
          // ready is tested first so it wins over a timeout in the same cycle
          if (io_rdy_sel) begin
            if (!we_q) cpu_rdata_q <= io_slice;
            state_q <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            state_q    <= S_DONE;
            cpu_err_q  <= 1'b1;
            err_addr_q <= addr_q;
            if (!we_q) cpu_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bus.sv
// Scoreboard bench for mem_io_bus with MEM_LAT=2, TIMEOUT=8, N_IO=4.
module tb_mem_io_bus;

  localparam int LAT = 2;
  localparam int TO  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, err_addr;
  logic         cpu_stall, cpu_err;
  logic         mem_en, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   io_sel;
  logic         io_we;
  logic [3:0]   io_addr;
  logic [31:0]  io_wdata;
  logic [127:0] io_rdata;
  logic [3:0]   io_ready;

  mem_io_bus #(.MEM_LAT(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err), .err_addr(err_addr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    int          stall;
    int          n_en;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          stall_cnt = 0;
  int          en_cnt = 0;
  logic [31:0] model_rdata = '0;
  logic [31:0] model_eaddr = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [3:0] sel, input int stall, input int n_en,
                       input logic err, input logic [31:0] rd);
    exp_t e;
    if (err) model_eaddr = addr;
    if (!we) model_rdata = err ? 32'h0 : rd;
    e.addr = addr; e.wdata = wdata; e.we = we; e.sel = sel;
    e.stall = stall; e.n_en = n_en; e.err = err;
    e.rdata = model_rdata; e.eaddr = model_eaddr;
    sb.push_back(e);
    cpu_addr = addr; cpu_wdata = wdata; cpu_we = we; cpu_req = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (cpu_stall && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (cpu_stall) begin
      chk("done_timeout", 1, 0);
      sb.delete();
      stall_cnt = 0;
      en_cnt = 0;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && cpu_req && sb.size() > 0) begin
      e = sb[0];
      if (mem_en) begin
        en_cnt++;
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.we);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
      if (io_sel != 4'b0) begin
        chk("io_sel", io_sel, e.sel);
        chk("io_addr", io_addr, e.addr[3:0]);
        chk("io_we", io_we, e.we);
        if (e.we) chk("io_wdata", io_wdata, e.wdata);
      end
      if (cpu_stall) begin
        stall_cnt++;
      end else begin
        chk("stall_cycles", stall_cnt, e.stall);
        chk("mem_en_pulses", en_cnt, e.n_en);
        chk("cpu_err", cpu_err, e.err);
        chk("err_addr", err_addr, e.eaddr);
        chk("cpu_rdata", cpu_rdata, e.rdata);
        void'(sb.pop_front());
        stall_cnt = 0;
        en_cnt = 0;
      end
    end
  end

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = 32'hBAD0_BAD0;
    io_rdata  = {4{32'hEEEE_EEEE}};
    io_ready  = 4'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_cpu_err", cpu_err, 1'b0);
    chk("rst_io_sel", io_sel, 4'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_cpu_stall", cpu_stall, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Memory load: data only valid on the capture cycle
    issue(32'h0000_0040, 32'h0, 1'b0, 4'b0, LAT + 1, 1, 1'b0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rdata = 32'hBAD0_BAD0;
    wait_done();

    issue(32'h0000_0010, 32'h0000_1234, 1'b1, 4'b0, 1, 1, 1'b0, 32'h0);
    wait_done();

    // IO load on channel 2; a stray ready on channel 1 must be ignored
    io_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    issue(32'hFFFF_FC24, 32'h0, 1'b0, 4'b0100, 7, 0, 1'b0, 32'h0000_00A5);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      io_ready = (i == 2) ? 4'b0010 : 4'b0000;
      @(posedge clk); #1;
    end
    io_ready = 4'b0100;
    io_rdata[64 +: 32] = 32'h0000_00A5;
    @(posedge clk); #1;
    io_ready = 4'b0;
    io_rdata[64 +: 32] = 32'h2222_2222;
    wait_done();

    io_rdata[96 +: 32] = 32'h3C3C_0001;
    io_ready = 4'b1000;
    issue(32'hFFFF_FC3C, 32'h0, 1'b0, 4'b1000, 2, 0, 1'b0, 32'h3C3C_0001);
    wait_done();
    io_ready = 4'b0;

    issue(32'hFFFF_FC00, 32'h0000_0055, 1'b1, 4'b0001, TO + 1, 0, 1'b1, 32'h0);
    wait_done();

    // Ready on the last permitted wait cycle beats the timeout
    issue(32'hFFFF_FC00, 32'h0000_0066, 1'b1, 4'b0001, TO + 1, 0, 1'b0, 32'h0);
    @(posedge clk); #1;
    repeat (TO - 1) begin @(posedge clk); #1; end
    io_ready = 4'b0001;
    @(posedge clk); #1;
    io_ready = 4'b0;
    wait_done();

    issue(32'hFFFF_FC40, 32'h0, 1'b0, 4'b0, 1, 0, 1'b1, 32'h0);
    wait_done();

    // Abort an IO wait with reset
    issue(32'hFFFF_FC30, 32'h0, 1'b0, 4'b1000, 0, 0, 1'b0, 32'h0);
    repeat (4) begin @(posedge clk); #1; end
    #1;
    rst = 1'b0;
    #1;
    chk("abort_io_sel", io_sel, 4'b0);
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_cpu_err", cpu_err, 1'b0);
    chk("abort_cpu_rdata", cpu_rdata, 32'h0);
    chk("abort_err_addr", err_addr, 32'h0);
    sb.delete();
    stall_cnt = 0;
    en_cnt = 0;
    model_rdata = '0;
    model_eaddr = '0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    issue(32'h0000_0080, 32'h0, 1'b0, 4'b0, LAT + 1, 1, 1'b0, 32'hCAFE_F00D);
    @(posedge clk); #1;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rdata = 32'hBAD0_BAD0;
    wait_done();

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
